// File: rtl/cc_pkg.sv
// Shared widths, state encoding and sort-entry layout for the streaming class-score calculator.
package cc_pkg;
  localparam int N_STU = 7;
  localparam int SW    = 4;
  localparam int SC_W  = SW + 1;
  localparam int ID_W  = 3;
  localparam int SUM_W = 8;
  localparam int THR_W = 6;
  localparam int XF_W  = 8;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  typedef struct packed {
    logic [SC_W-1:0] score;
    logic [ID_W-1:0] id;
  } ent_t;
endpackage

// File: rtl/cc_score_xform.sv
// Combinational scale/offset of one sorted score and its compare against the pass threshold.
// Negative scores are divided by k (truncating toward zero), non-negative ones multiplied by k.
module cc_score_xform
  import cc_pkg::*;
(
  input  logic        [SC_W-1:0]  score_i,
  input  logic        [1:0]       a_i,
  input  logic        [2:0]       b_i,
  input  logic        [THR_W-1:0] pass_i,
  output logic signed [XF_W-1:0]  xf_o,
  output logic                    pass_o
);
  logic signed [XF_W-1:0] s_ext, k_ext, b_ext, p_ext, scaled;

  always_comb begin
    s_ext  = {{(XF_W-SC_W){score_i[SC_W-1]}}, score_i};
    k_ext  = {{(XF_W-2){1'b0}}, a_i} + XF_W'(1);
    b_ext  = {{(XF_W-3){1'b0}}, b_i};
    p_ext  = {{(XF_W-THR_W){pass_i[THR_W-1]}}, pass_i};
    scaled = s_ext[XF_W-1] ? (s_ext / k_ext) : (s_ext * k_ext);
    xf_o   = scaled + b_ext;
    pass_o = (xf_o >= p_ext);
  end
endmodule

// File: rtl/cc_stream.sv
// Serial 7-score frame: insertion-sort on load, 7-cycle pass count, 7-beat sorted ID stream.
// Results start 8 cycles after the last accepted beat; in_ready drops for CALC/OUT, no output stall.
module cc_stream
  import cc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SW-1:0]   in_score,
  input  logic [2:0]      opt,
  input  logic [1:0]      a,
  input  logic [2:0]      b,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic [2:0]      out_count
);
  state_t                 state_q;
  ent_t [N_STU-1:0]       arr_q, base, ins;
  ent_t                   new_ent;
  logic [2:0]             cnt_q, fcnt_q, pos, tot;
  logic [2:0]             opt_q, b_q, op_eff;
  logic [1:0]             a_q;
  logic [THR_W-1:0]       pass_q, pass_d;
  logic signed [SUM_W-1:0] sum_q, sum_d, mean;
  logic [SC_W-1:0]        new_sc;
  logic                   out_valid_q;
  logic [ID_W-1:0]        out_id_q;
  logic [2:0]             out_count_q;
  logic signed [XF_W-1:0] xf;
  logic                   pass_flg;

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_count = out_count_q;

  // Beat 0 arrives in IDLE, before opt is latched, so it uses the live inputs.
  always_comb begin
    op_eff        = (state_q == IDLE) ? opt : opt_q;
    new_sc        = op_eff[0] ? {in_score[SW-1], in_score} : {1'b0, in_score};
    new_ent.score = new_sc;
    new_ent.id    = cnt_q;
    base          = (state_q == IDLE) ? '0 : arr_q;
    sum_d         = ((state_q == IDLE) ? '0 : sum_q) + {{(SUM_W-SC_W){new_sc[SC_W-1]}}, new_sc};
    mean          = sum_d / 8'sd7;
    pass_d        = mean[THR_W-1:0] - {{(THR_W-2){1'b0}}, a_q};
    tot           = fcnt_q + {2'b0, pass_flg};
    // Equal scores count as "before" the newcomer in both directions, keeping ties in ID order.
    pos = '0;
    for (int i = 0; i < N_STU; i++) begin
      if (i < int'(cnt_q)) begin
        if (op_eff[1] ? ($signed(base[i].score) >= $signed(new_sc))
                      : ($signed(base[i].score) <= $signed(new_sc)))
          pos = pos + 3'd1;
      end
    end
    ins    = base;
    ins[0] = (pos == 3'd0) ? new_ent : base[0];
    for (int i = 1; i < N_STU; i++) begin
      if (3'(i) == pos)     ins[i] = new_ent;
      else if (3'(i) > pos) ins[i] = base[i-1];
    end
  end

  cc_score_xform u_xform (
    .score_i (arr_q[cnt_q].score),
    .a_i     (a_q),
    .b_i     (b_q),
    .pass_i  (pass_q),
    .xf_o    (xf),
    .pass_o  (pass_flg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arr_q       <= '0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      sum_q       <= '0;
      pass_q      <= '0;
      opt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          opt_q   <= opt;
          a_q     <= a;
          b_q     <= b;
          arr_q   <= ins;
          sum_q   <= sum_d;
          fcnt_q  <= '0;
          cnt_q   <= 3'd1;
          state_q <= LOAD;
        end
        LOAD: if (in_valid) begin
          arr_q <= ins;
          sum_q <= sum_d;
          if (cnt_q == 3'd6) begin
            pass_q  <= pass_d;
            cnt_q   <= '0;
            state_q <= CALC;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        CALC: begin
          fcnt_q <= tot;
          if (cnt_q == 3'd6) begin
            out_count_q <= opt_q[2] ? (3'd7 - tot) : tot;
            out_valid_q <= 1'b1;
            out_id_q    <= arr_q[0].id;
            cnt_q       <= '0;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        OUT: begin
          if (cnt_q == 3'd6) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            out_id_q <= arr_q[cnt_q + 3'd1].id;
            cnt_q    <= cnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Transformed score stays within -8..67 for every legal score/a/b combination.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == CALC) |-> (xf >= -8'sd8 && xf <= 8'sd67));
endmodule

// File: tb/tb_cc_stream.sv
// Directed frame table plus gap/hold and mid-frame reset sequences for cc_stream.
module tb_cc_stream;
  logic       clk, rst, in_valid, in_ready, out_valid;
  logic [3:0] in_score;
  logic [2:0] opt_in, b_in, out_id, out_count;
  logic [1:0] a_in;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  cc_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .opt       (opt_in),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]      opt;
    logic [1:0]      a;
    logic [2:0]      b;
    logic [6:0][3:0] sc;
    logic [6:0][2:0] id;
    logic [2:0]      cnt;
  } frame_t;

  frame_t frames [12];

  function automatic frame_t mk(input logic [2:0] o, input logic [1:0] aa, input logic [2:0] bb,
                                input logic [27:0] s, input logic [20:0] ids, input logic [2:0] c);
    frame_t f;
    f.opt = o;
    f.a   = aa;
    f.b   = bb;
    f.cnt = c;
    for (int k = 0; k < 7; k++) begin
      f.sc[k] = s[27-4*k -: 4];
      f.id[k] = ids[20-3*k -: 3];
    end
    return f;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int fi, input bit gaps, input bit hold, input bit abort);
    frame_t f;
    int     t_last, waitc, r;
    f = frames[fi];
    t_last = 0;
    for (int k = 0; k < 7; k++) begin
      if (gaps) repeat (k % 3) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_score = f.sc[k];
      opt_in   = (k == 0) ? f.opt : ~f.opt;
      a_in     = (k == 0) ? f.a   : ~f.a;
      b_in     = (k == 0) ? f.b   : ~f.b;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) chk($sformatf("f%0d ready_timeout", fi), 0, 1);
      t_last = cyc;
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = hold;
        in_score = 4'hA;
      end
      if (c == 15) in_valid = 1'b0;
      r = cyc - t_last - 8;
      chk($sformatf("f%0d out_valid c%0d", fi, c), int'(out_valid), (r >= 0 && r < 7) ? 1 : 0);
      if (r >= 0 && r < 7) begin
        chk($sformatf("f%0d out_id r%0d", fi, r), int'(out_id), int'(f.id[r]));
        chk($sformatf("f%0d out_count r%0d", fi, r), int'(out_count), int'(f.cnt));
      end
      if (c == 1)  chk($sformatf("f%0d in_ready_calc", fi), int'(in_ready), 0);
      if (c == 15) chk($sformatf("f%0d in_ready_back", fi), int'(in_ready), 1);
      if (c == 16) begin
        chk($sformatf("f%0d id_hold", fi), int'(out_id), int'(f.id[6]));
        chk($sformatf("f%0d count_hold", fi), int'(out_count), int'(f.cnt));
      end
      if (abort && r == 3) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort out_id", int'(out_id), 0);
        chk("abort out_count", int'(out_count), 0);
        chk("abort in_ready", int'(in_ready), 1);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    frames[0]  = mk(3'b000, 2'd0, 3'd0, 28'h3141592, 21'o1360245, 3'd4);
    frames[1]  = mk(3'b010, 2'd0, 3'd0, 28'h3141592, 21'o5420613, 3'd4);
    frames[2]  = mk(3'b110, 2'd0, 3'd0, 28'h3141592, 21'o5420613, 3'd3);
    frames[3]  = mk(3'b001, 2'd1, 3'd2, 28'hF870D21, 21'o1403652, 3'd6);
    frames[4]  = mk(3'b101, 2'd1, 3'd2, 28'hF870D21, 21'o1403652, 3'd1);
    frames[5]  = mk(3'b000, 2'd3, 3'd0, 28'h5555555, 21'o0123456, 3'd7);
    frames[6]  = mk(3'b010, 2'd3, 3'd0, 28'h5555555, 21'o0123456, 3'd7);
    frames[7]  = mk(3'b011, 2'd2, 3'd0, 28'h8888888, 21'o0123456, 3'd7);
    frames[8]  = mk(3'b111, 2'd2, 3'd0, 28'h8888888, 21'o0123456, 3'd0);
    frames[9]  = mk(3'b001, 2'd2, 3'd0, 28'h95F0000, 21'o0234561, 3'd7);
    frames[10] = mk(3'b011, 2'd0, 3'd0, 28'hFFF0000, 21'o3456012, 3'd4);
    frames[11] = mk(3'b000, 2'd3, 3'd7, 28'hFFFFFFF, 21'o0123456, 3'd7);

    rst = 1'b1; in_valid = 1'b0; in_score = '0; opt_in = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_id", int'(out_id), 0);
    chk("reset out_count", int'(out_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_frame(i, 1'b0, 1'b0, 1'b0);

    run_frame(0, 1'b1, 1'b1, 1'b0);
    run_frame(3, 1'b1, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0, 1'b1);
    run_frame(3, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_score = 4'h9;
      opt_in   = 3'b010;
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(4, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
